// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and port identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the arbiter. MEM_ARB_RR_EN selects round-robin tie-breaking
// in IDLE; otherwise the data port wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
`ifdef MEM_ARB_RR_EN
    input  port_t  last,
`endif
    input  port_t  port,
    input  state_t state,
    output logic   grant,
    output port_t  winner
);

    always_comb begin
        grant  = 1'b0;
        winner = PORT_D;
        case (state)
            IDLE: begin
                grant = ireq | dreq;
                if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
                    winner = (last == PORT_D) ? PORT_I : PORT_D;
`else
                    winner = PORT_D;
`endif
                end else begin
                    winner = dreq ? PORT_D : PORT_I;
                end
            end
            // Only the port that was not just acked may take the handoff.
            DONE: begin
                if (port == PORT_I) begin
                    grant  = dreq;
                    winner = PORT_D;
                end else begin
                    grant  = ireq;
                    winner = PORT_I;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default build gives data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic        iack,
    output logic [31:0] irdata,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic        dack,
    output logic [31:0] drdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    if (MEM_LAT < 1) begin : g_lat_check
        $error("mem_arbiter: MEM_LAT must be at least 1");
    end

    state_t        state_q, state_d;
    port_t         port_q, port_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_we_q, op_we_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   irdata_q, irdata_d;
    logic [31:0]   drdata_q, drdata_d;
    logic          grant;
    port_t         winner;

`ifdef MEM_ARB_RR_EN
    port_t         last_q, last_d;
`endif

    mem_arb_pick u_pick (
        .ireq   (ireq),
        .dreq   (dreq),
`ifdef MEM_ARB_RR_EN
        .last   (last_q),
`endif
        .port   (port_q),
        .state  (state_q),
        .grant  (grant),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            port_q      <= PORT_I;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
            last_q      <= PORT_I;
`endif
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!op_we_q) begin
                        if (port_q == PORT_I) irdata_d = mem_rdata;
                        else                  drdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The picker only grants in IDLE or DONE, so this overrides the transitions above.
        if (grant) begin
            state_d    = WAIT;
            cnt_d      = CW'(MEM_LAT);
            port_d     = winner;
            op_we_d    = (winner == PORT_D) && dwe;
            mem_en_d   = 1'b1;
            mem_we_d   = (winner == PORT_D) && dwe;
            mem_addr_d = (winner == PORT_D) ? daddr : iaddr;
            if (winner == PORT_D) mem_wdata_d = dwdata;
`ifdef MEM_ARB_RR_EN
            last_d     = winner;
`endif
        end
    end

    always_comb begin
        iack = 1'b0;
        dack = 1'b0;
        if (state_q == DONE) begin
            iack = (port_q == PORT_I);
            dack = (port_q == PORT_D);
        end
        busy = (state_q != IDLE);
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign irdata    = irdata_q;
    assign drdata    = drdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and data-access port, for unified-memory builds of the pipelined MIPS core. It accepts a request from either port and arbitrates when both ask in the same cycle. It sequences the access on the memory side and returns read data with a one-cycle acknowledge. The pipeline stalls each stage on `req & ~ack`.

## Interface
- `MEM_LAT`, default 2: cycles from the memory-enable cycle to valid `mem_rdata`. Must be ≥1; 0 is an elaboration error.
- `clk` input, 1: clock. All state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `ireq` input, 1: instruction read request. Held until `iack`.
- `iaddr` input, 32: instruction address.
- `iack` output, 1: one-cycle pulse; `irdata` is valid in that cycle.
- `irdata` output, 32: instruction read data. Holds its value until the next instruction ack.
- `dreq` input, 1: data request. Held until `dack`.
- `dwe` input, 1: data write enable (1 = write, 0 = read).
- `daddr` input, 32: data address.
- `dwdata` input, 32: data write data.
- `dack` output, 1: one-cycle pulse completing the data access.
- `drdata` output, 32: data read data. Holds its value until the next data read ack.
- `mem_en` output, 1: memory access strobe, high for exactly one cycle per access.
- `mem_we` output, 1: memory write strobe, only ever high together with `mem_en`.
- `mem_addr` output, 32: memory address, registered and held from issue until ack.
- `mem_wdata` output, 32: memory write data, registered.
- `mem_rdata` input, 32: memory read data.
- `busy` output, 1: high whenever the state is not IDLE.

## Operation
- **States:**
  - IDLE: no access outstanding.
  - WAIT: access issued; counting latency.
  - DONE: ack cycle.
- **IDLE:**
  - If any request is present, pick a winner at the clock edge.
  - Latch the winner's address, write enable, write data and port id.
  - Load the counter with `MEM_LAT`.
  - Move to WAIT.
- **WAIT:**
  - `mem_en` (and `mem_we` for writes) is high in the first WAIT cycle only.
  - The counter decrements each cycle.
  - When the counter reaches 0, capture `mem_rdata` into the granted port's read-data register (reads only) and move to DONE.
- **DONE:**
  - Pulse the granted port's ack.
  - The acked port's request is ignored in this cycle.
  - If the other port is requesting, grant it immediately (same as IDLE grant) and move to WAIT. Otherwise move to IDLE.
- **Writes:** acked with the same timing as reads; `drdata` is not updated.
- **Default arbitration on a tie in IDLE:** the data port wins (older instruction first).
- **Counter width:** $clog2(MEM_LAT+1). No wrap is possible.
- **Reset (asynchronous, including mid-access):**
  - State returns to IDLE and the counter to 0.
  - `iack`, `dack`, `mem_en`, `mem_we` and `busy` go to 0.
  - `mem_addr`, `mem_wdata`, `irdata` and `drdata` go to 0.
  - The RR pointer is set to "instruction".
  - Any in-flight memory result is discarded and never acked.

## Timing
- Cycle 0: request sampled (state IDLE). Cycle 1: `mem_en` high. Cycle 1+MEM_LAT: memory drives `mem_rdata`. Cycle 2+MEM_LAT: ack high with data.
- Request-to-ack latency is MEM_LAT+2 cycles; with MEM_LAT=2 the ack arrives in cycle 4.
- Back-to-back accesses from alternating ports: one access completes every MEM_LAT+2 cycles with no idle gap.
- The same port issuing consecutively pays one extra IDLE cycle.
- `iack` and `dack` are never high in the same cycle.

## Configuration
- **Macro:** `MEM_ARB_RR_EN`.
- **Defined:** round-robin arbitration. A last-grant pointer updates on every grant. On a tie in IDLE, the port not granted last wins. The pointer resets to "instruction", so the first tie goes to data.
- **Undefined:** fixed data-first priority on a tie in IDLE; no pointer register.
- DONE-state handoff to the other port behaves identically in both builds.

## Structure
- **Package `mem_arb_pkg`:** state enum (IDLE, WAIT, DONE) and port-id enum (PORT_I, PORT_D).
- **Sub-module `mem_arb_pick`:** winner selection from `ireq`, `dreq`, the pointer and the current state. Purely combinational. Its `MEM_ARB_RR_EN` branch is the only macro-dependent code.

## Test plan
1. **Reset:** assert `reset` with random inputs. Every output is 0 immediately (asynchronous) and `busy` is 0.
2. **Instruction read, MEM_LAT=2:**
   - Stimulus: `ireq` with `iaddr`=0x40 at cycle 0; memory returns 0x20080005.
   - Expected: `mem_en` high in cycle 1 only with `mem_addr`=0x40; `iack` in cycle 4 with `irdata`=0x20080005.
3. **Data write:**
   - Stimulus: `dreq`, `dwe`, `daddr`=0x54, `dwdata`=0xDEADBEEF.
   - Expected: `mem_en` and `mem_we` high for one cycle with those values; `dack` in cycle 4; `drdata` unchanged.
4. **Tie, macro undefined:**
   - Stimulus: `ireq` and `dreq` asserted together in cycle 0.
   - Expected: `dack` in cycle 4; instruction issued in cycle 5 (`mem_en` high); `iack` in cycle 8.
5. **Tie, macro defined:**
   - Stimulus: `ireq` and `dreq` held continuously.
   - Expected: acks alternate D, I, D, I every 4 cycles.
6. **Reset mid-access:**
   - Stimulus: assert `reset` in cycle 2 of a read.
   - Expected: no ack pulses. After release, a new `ireq` completes normally with 4-cycle latency.
